song_reader: RTL and testbench
==============================

# song_reader

Sequencer between the song ROM and the note player. It walks the note list of the selected song, fetching one {note, duration} entry at a time. Each entry is handed to the note player with a one-cycle `new_note` strobe, and the reader waits for `note_done` before fetching the next entry. The top-level play controller drives this block through `play`, `reset_play` and `next_song`, and receives `song_done` back at end of song.

## Interface
- `SONG_BITS`, 2: song index width (4 songs).
- `NOTE_ADDR_BITS`, 5: note index width (32 entries per song).
- `NOTE_W`, 6: note code width.
- `DUR_W`, 6: duration field width. A duration of 0 is the end-of-song marker.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `play` in 1: level. 1 = advance through the song; 0 = hold before the next fetch.
- `reset_play` in 1: pulse. Restart the current song from note 0.
- `next_song` in 1: pulse. Select the next song (wraps) and restart from note 0.
- `note_done` in 1: pulse from the note player. The current note has finished.
- `rom_addr` out SONG_BITS+NOTE_ADDR_BITS: registered `{song, note_idx}`.
- `rom_data` in NOTE_W+DUR_W: `{note, duration}`. Synchronous ROM, valid one cycle after `rom_addr`.
- `new_note` out 1: one-cycle strobe. `note`/`duration` are valid and new.
- `note` out NOTE_W: latched note code.
- `duration` out DUR_W: latched duration.
- `song_done` out 1: one-cycle strobe at end of song.
- `song` out SONG_BITS: current song index.

## Operation
- Internal state: `song`, `note_idx`, and a state machine with states IDLE, FETCH, ISSUE, WAIT_DONE, DONE.
- `rom_addr` is registered as `{song, note_idx}` every cycle.
- **IDLE**
  - `play`=1 → FETCH.
  - Otherwise hold.
- **FETCH**
  - The address is presented and the ROM reads.
  - `play`=1 → ISSUE; `play`=0 → stay in FETCH.
- **ISSUE**
  - `rom_data` is valid and is sampled.
  - If duration==0: pulse `song_done` next cycle; → DONE. `note`/`duration` are not updated.
  - Otherwise: latch `note`/`duration`, pulse `new_note` next cycle; → WAIT_DONE.
- **WAIT_DONE**
  - Wait for `note_done`. It is accepted in every WAIT_DONE cycle, including the first, and regardless of `play`.
  - On `note_done` with `note_idx`==2^NOTE_ADDR_BITS−1: pulse `song_done`; → DONE.
  - On `note_done` otherwise: `note_idx`+1; → FETCH.
- **DONE**
  - Hold; `new_note` stays 0.
  - Only `reset_play`, `next_song` or `reset` leave this state.
- **Priority**, highest first: `reset` > `next_song` > `reset_play` > state-machine transition.
  - `next_song`: `song`←`song`+1 (modulo 2^SONG_BITS), `note_idx`←0, → IDLE.
  - `reset_play`: `note_idx`←0, → IDLE, `song` unchanged.
  - Simultaneous `next_song` and `reset_play`: the `next_song` result applies.
  - Either pulse aborts any in-flight fetch or note. No `new_note` or `song_done` is emitted in the cycle after the abort.
- **Reset**: state IDLE, `song`=0, `note_idx`=0, `rom_addr`=0, `note`=0, `duration`=0, `new_note`=0, `song_done`=0.
- `note`/`duration` hold their last values until the next ISSUE with a nonzero duration.
- `note_done` outside WAIT_DONE is ignored.

## Timing
- All outputs are registered. `new_note` and `song_done` are never high for more than one cycle, and are never high in the same cycle.
- Play start, edge k samples `play`=1 in IDLE:
  - FETCH during k+1.
  - ISSUE during k+2.
  - `new_note`=1 and new `note`/`duration` during k+3, which is the first WAIT_DONE cycle.
- Note-to-note: `note_done` sampled at edge m → `new_note` during m+3.
  - Minimum spacing between `new_note` strobes is 4 cycles.
- End of song:
  - Zero-duration marker sampled at ISSUE edge → `song_done` in the following cycle.
  - Last-index `note_done` at edge m → `song_done` during m+1.
- `play` dropping to 0 during WAIT_DONE does not stall acceptance of `note_done`. The stall takes effect in FETCH.
- `next_song`/`reset_play` sampled at edge j → IDLE and the new `rom_addr` are visible during j+1.

## Test plan
1. **Reset.** Assert `reset` 2 cycles.
   - Expect all outputs 0 and state IDLE.
   - With `play`=0, 10 cycles → no `new_note`.
2. **Short song.** Song 0 ROM = {5,3},{9,4},{0x12,1},{x,0}. Hold `play`=1; answer each `new_note` with `note_done` 2 cycles later.
   - Expect 3 `new_note` strobes with `note`=5,9,0x12 and `duration`=3,4,1.
   - Expect `rom_addr`=0,1,2,3.
   - Expect a single `song_done`, then DONE with no further strobes.
3. **Full song.** Song 1 has 32 nonzero entries.
   - Expect 32 `new_note` strobes and `song_done` one cycle after the 32nd `note_done`.
   - `note_idx` never wraps into a 33rd fetch.
4. **next_song mid-note.** Pulse `next_song` in WAIT_DONE of song 3, note 4.
   - Expect `song`=0, `rom_addr`=0 next cycle, and no `song_done`.
   - Replay starts at song 0, entry 0.
5. **Pause and restart.**
   - Drop `play` in WAIT_DONE; give `note_done` → state stalls in FETCH with `rom_addr`=next entry.
   - Raise `play` → `new_note` 2 cycles later.
   - `reset_play` in DONE → restart at note 0 of the same song.
6. **Simultaneous pulses.** `next_song` and `reset_play` in the same cycle while in song 2.
   - Expect `song`=3 and `note_idx`=0.
   - Then `reset` in the same cycle as `note_done` → all reset values, no strobe.

Source files
------------

// File: rtl/song_reader.sv
// Walks the {note, duration} list of the selected song in a synchronous ROM and
// hands each entry to the note player, waiting for note_done between entries.
module song_reader #(
    parameter int SONG_BITS      = 2,
    parameter int NOTE_ADDR_BITS = 5,
    parameter int NOTE_W         = 6,
    parameter int DUR_W          = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                play,
    input  logic                                reset_play,
    input  logic                                next_song,
    input  logic                                note_done,
    output logic [SONG_BITS+NOTE_ADDR_BITS-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]             rom_data,
    output logic                                new_note,
    output logic [NOTE_W-1:0]                   note,
    output logic [DUR_W-1:0]                    duration,
    output logic                                song_done,
    output logic [SONG_BITS-1:0]                song
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_DONE,
        DONE
    } state_t;

    localparam logic [NOTE_ADDR_BITS-1:0] LAST_IDX = '1;

    state_t                              state_q, state_d;
    logic [SONG_BITS-1:0]                song_q, song_d;
    logic [NOTE_ADDR_BITS-1:0]           note_idx_q, note_idx_d;
    logic [SONG_BITS+NOTE_ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0]                   note_q, note_d;
    logic [DUR_W-1:0]                    duration_q, duration_d;
    logic                                new_note_q, new_note_d;
    logic                                song_done_q, song_done_d;

    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        note_idx_d  = note_idx_q;
        note_d      = note_q;
        duration_d  = duration_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (play) state_d = FETCH;
            end
            FETCH: begin
                if (play) state_d = ISSUE;
            end
            ISSUE: begin
                // A zero duration marks the end of the song and is never latched.
                if (rom_dur == '0) begin
                    song_done_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    note_d      = rom_note;
                    duration_d  = rom_dur;
                    new_note_d  = 1'b1;
                    state_d     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (note_done) begin
                    if (note_idx_q == LAST_IDX) begin
                        song_done_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        note_idx_d  = note_idx_q + 1'b1;
                        state_d     = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Control pulses abort whatever is in flight, including a pending strobe.
        if (next_song) begin
            song_d      = song_q + 1'b1;
            note_idx_d  = '0;
            state_d     = IDLE;
            note_d      = note_q;
            duration_d  = duration_q;
            new_note_d  = 1'b0;
            song_done_d = 1'b0;
        end else if (reset_play) begin
            note_idx_d  = '0;
            state_d     = IDLE;
            note_d      = note_q;
            duration_d  = duration_q;
            new_note_d  = 1'b0;
            song_done_d = 1'b0;
        end

        rom_addr_d = {song_d, note_idx_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            song_q      <= '0;
            note_idx_q  <= '0;
            rom_addr_q  <= '0;
            note_q      <= '0;
            duration_q  <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            song_q      <= song_d;
            note_idx_q  <= note_idx_d;
            rom_addr_q  <= rom_addr_d;
            note_q      <= note_d;
            duration_q  <= duration_d;
            new_note_q  <= new_note_d;
            song_done_q <= song_done_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign new_note  = new_note_q;
    assign note      = note_q;
    assign duration  = duration_q;
    assign song_done = song_done_q;
    assign song      = song_q;

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: a ROM model, a randomized note player, and a
// song-level reference that lists the strobes each (re)started song must produce.
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0;
    logic        reset_play = 1'b0;
    logic        next_song = 1'b0;
    logic        note_done;
    logic        stim_done = 1'b0;
    logic        resp_done = 1'b0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        song_done;
    logic [1:0]  song;

    typedef struct packed {
        logic       is_done;
        logic [6:0] addr;
        logic [5:0] note;
        logic [5:0] dur;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] rom_mem[128];
    logic [1:0]  model_song = 2'd0;
    logic [5:0]  last_note = 6'd0;
    logic [5:0]  last_dur = 6'd0;
    int          errors = 0;
    int          checks = 0;
    bit          respond_en = 1'b1;
    bit          hold_en = 1'b0;
    logic [6:0]  hold_addr = 7'd0;

    assign note_done = stim_done | resp_done;

    always #5 clk = ~clk;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .reset_play(reset_play),
        .next_song (next_song),
        .note_done (note_done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .new_note  (new_note),
        .note      (note),
        .duration  (duration),
        .song_done (song_done),
        .song      (song)
    );

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: a song plays its entries in order until a zero duration or the last slot.
    task automatic expectSong(input logic [1:0] s);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.addr    = 7'(int'(s) * 32 + i);
            e.note    = rom_mem[e.addr][11:6];
            e.dur     = rom_mem[e.addr][5:0];
            e.is_done = (e.dur == 6'd0);
            if (e.is_done) begin
                e.note = 6'd0;
                exp_q.push_back(e);
                return;
            end
            exp_q.push_back(e);
        end
        e = '{is_done: 1'b1, addr: 7'(int'(s) * 32 + 31), note: 6'd0, dur: 6'd0};
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input bit ns, input bit rp);
        @(posedge clk);
        #1;
        next_song  = ns;
        reset_play = rp;
        @(posedge clk);
        #1;
        next_song  = 1'b0;
        reset_play = 1'b0;
        exp_q.delete();
        if (ns) model_song = model_song + 2'd1;
        checkOutput("song after pulse", 32'(song), 32'(model_song));
        checkOutput("rom_addr after pulse", 32'(rom_addr), 32'({model_song, 5'd0}));
        checkOutput("no strobe after pulse", 32'({new_note, song_done}), 32'd0);
        expectSong(model_song);
    endtask

    task automatic waitDrain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic waitNewNote(input logic [6:0] addr, input int budget, input string name);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (new_note === 1'b1 && rom_addr === addr) seen = 1'b1;
            n++;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    // Monitor: every strobe must match the head of the scoreboard queue.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (new_note && song_done) checkOutput("exclusive strobes", 32'd1, 32'd0);
            if (new_note || song_done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected strobe", 32'({new_note, song_done}), 32'd0);
                end else begin
                    it = exp_q.pop_front();
                    checkOutput("strobe kind", 32'(song_done), 32'(it.is_done));
                    checkOutput("strobe rom_addr", 32'(rom_addr), 32'(it.addr));
                    checkOutput("strobe song", 32'(song), 32'(it.addr[6:5]));
                    if (it.is_done) begin
                        checkOutput("held note", 32'(note), 32'(last_note));
                        checkOutput("held duration", 32'(duration), 32'(last_dur));
                    end else begin
                        checkOutput("note", 32'(note), 32'(it.note));
                        checkOutput("duration", 32'(duration), 32'(it.dur));
                        last_note = it.note;
                        last_dur  = it.dur;
                    end
                end
            end
        end
    end

    // Note player: answers each new_note after a random 0..3 cycle delay.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (new_note === 1'b1 && respond_en && !(hold_en && rom_addr === hold_addr)) begin
                d = $urandom_range(0, 3);
                if (d != 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                end
                resp_done = 1'b1;
                @(posedge clk);
                #1;
                resp_done = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int m;
        for (int i = 0; i < 128; i++)
            rom_mem[i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
        rom_mem[0] = {6'd5, 6'd3};
        rom_mem[1] = {6'd9, 6'd4};
        rom_mem[2] = {6'h12, 6'd1};
        rom_mem[3] = {6'($urandom_range(0, 63)), 6'd0};
        m = $urandom_range(0, 40);
        if (m < 32) rom_mem[64 + m][5:0] = 6'd0;
        m = $urandom_range(8, 40);
        if (m < 32) rom_mem[96 + m][5:0] = 6'd0;

        // Reset and idle hold
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("reset note", 32'(note), 32'd0);
        checkOutput("reset duration", 32'(duration), 32'd0);
        checkOutput("reset new_note", 32'(new_note), 32'd0);
        checkOutput("reset song_done", 32'(song_done), 32'd0);
        checkOutput("reset song", 32'(song), 32'd0);
        repeat (10) @(posedge clk);

        // Short song 0 with start latency
        expectSong(2'd0);
        #1;
        play = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("start latency early", 32'(new_note), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("start latency", 32'(new_note), 32'd1);
        waitDrain(200, "short song drained");
        repeat (10) @(posedge clk);

        // Full 32-entry song 1
        applyStimulus(1'b1, 1'b0);
        waitDrain(600, "full song drained");
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no wrap past last entry", 32'(rom_addr), 32'h3F);

        // Song 2 with random play gating
        applyStimulus(1'b1, 1'b0);
        for (int n = 0; n < 1500 && exp_q.size() != 0; n++) begin
            play = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        play = 1'b1;
        checkOutput("gated song drained", 32'(exp_q.size()), 32'd0);

        // next_song in WAIT_DONE of song 3, note 4
        hold_addr = 7'h64;
        hold_en   = 1'b1;
        applyStimulus(1'b1, 1'b0);
        waitNewNote(7'h64, 200, "reach song 3 note 4");
        applyStimulus(1'b1, 1'b0);
        hold_en = 1'b0;
        waitDrain(200, "replay song 0 drained");

        // Pause in WAIT_DONE, stall in FETCH, resume; reset_play from DONE
        applyStimulus(1'b0, 1'b1);
        waitNewNote(7'h00, 50, "restart note 0");
        @(posedge clk);
        #1;
        play = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("stalled rom_addr", 32'(rom_addr), 32'h01);
        checkOutput("stalled no strobe", 32'(new_note), 32'd0);
        play = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resume latency early", 32'(new_note), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("resume latency", 32'(new_note), 32'd1);
        waitDrain(200, "resumed song drained");

        // Simultaneous pulses, then reset colliding with note_done
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        respond_en = 1'b0;
        applyStimulus(1'b1, 1'b1);
        waitNewNote(7'h60, 50, "song 3 first note");
        @(posedge clk);
        #1;
        reset     = 1'b1;
        stim_done = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        stim_done = 1'b0;
        play      = 1'b0;
        exp_q.delete();
        model_song = 2'd0;
        last_note  = 6'd0;
        last_dur   = 6'd0;
        checkOutput("post-reset rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("post-reset note", 32'(note), 32'd0);
        checkOutput("post-reset duration", 32'(duration), 32'd0);
        checkOutput("post-reset song", 32'(song), 32'd0);
        checkOutput("post-reset strobes", 32'({new_note, song_done}), 32'd0);
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
